// File: rtl/rr_arb_pkg.sv
// rr_arb_pkg -- shared types and helpers for the round-robin slice arbiter.
//
// Contents:
//   arb_state_e   : two-state arbiter FSM encoding (IDLE / GRANT)
//   MAX_REQ       : widest requester vector the helpers accept
//   onehot_to_id  : index of the set bit in a one-hot (or zero) vector
package rr_arb_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  localparam int MAX_REQ = 16;

  // Converts a one-hot vector to the index of its set bit. A zero vector
  // yields 0, which is exactly what grant_id must show while nothing is
  // granted, so callers need no special case for the idle state.
  function automatic int onehot_to_id(input logic [MAX_REQ-1:0] oh);
    int id;
    id = 0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) begin
        id = i;
      end
    end
    return id;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick -- combinational rotate-and-priority search.
//
// Starting at position ptr and ascending (wrapping from N_REQ-1 to 0), finds
// the first asserted bit of req.
//
// Ports:
//   req   [N_REQ-1:0]         in  : request vector
//   ptr   [$clog2(N_REQ)-1:0] in  : position where the search begins
//   found                     out : at least one request bit is set
//   index [$clog2(N_REQ)-1:0] out : first requester found (0 when !found)
module rr_pick #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic                     found,
  output logic [$clog2(N_REQ)-1:0] index
);

  localparam int ID_W = $clog2(N_REQ);

  logic [ID_W-1:0] pos_s;

  // Walk the rotated positions from farthest to nearest so the nearest hit,
  // written last, is the one that survives.
  always_comb begin
    found = 1'b0;
    index = {ID_W{1'b0}};
    pos_s = {ID_W{1'b0}};
    for (int i = N_REQ - 1; i >= 0; i--) begin
      pos_s = ID_W'((int'(ptr) + i) % N_REQ);
      if (req[pos_s]) begin
        found = 1'b1;
        index = pos_s;
      end else begin
        found = found;
        index = index;
      end
    end
  end

endmodule

// File: rtl/rr_slice_arbiter.sv
// rr_slice_arbiter -- round-robin arbiter with a bounded grant length.
//
// One requester owns the grant at a time. The owner keeps it while its req
// stays high, up to SLICE_CYCLES cycles; the grant then moves to the next
// requester in rotating order (or back to the owner if nobody else waits).
//
// Parameters:
//   N_REQ        : number of requesters (2..16)
//   SLICE_CYCLES : maximum grant length in clk cycles (>= 1)
//   CNT_W        : slice counter width, 2**CNT_W > SLICE_CYCLES
//
// Ports:
//   clk                        in  : rising-edge clock
//   reset                      in  : synchronous, active-high reset
//   req           [N_REQ-1:0]  in  : level request per requester
//   grant         [N_REQ-1:0]  out : registered grant, one-hot or zero
//   grant_valid                out : grant is non-zero
//   grant_id      [clog2-1:0]  out : index of the granted requester, else 0
//   slice_expired              out : one-cycle pulse when a grant ends by
//                                    slice timeout with its req still high
module rr_slice_arbiter
  import rr_arb_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int SLICE_CYCLES = 150000000,
  parameter int CNT_W        = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req,
  output logic [N_REQ-1:0]         grant,
  output logic                     grant_valid,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     slice_expired
);

  localparam int ID_W = $clog2(N_REQ);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLICE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [ID_W-1:0]  ID_ZERO  = {ID_W{1'b0}};
  localparam logic [ID_W-1:0]  ID_ONE   = ID_W'(1);
  localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(N_REQ - 1);
  localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

  // Registered state. grant_id_r doubles as the owner index in GRANT.
  arb_state_e        state_r;
  logic [ID_W-1:0]   ptr_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [N_REQ-1:0]  grant_r;
  logic              grant_valid_r;
  logic [ID_W-1:0]   grant_id_r;

  // Next-state values.
  arb_state_e        state_nxt_s;
  logic [ID_W-1:0]   ptr_nxt_s;
  logic [CNT_W-1:0]  cnt_nxt_s;
  logic [N_REQ-1:0]  grant_nxt_s;
  logic              grant_valid_nxt_s;
  logic [ID_W-1:0]   grant_id_nxt_s;

  // Release decode and search.
  logic              owner_req_s;
  logic              timeout_s;
  logic              release_s;
  logic              expire_s;
  logic [ID_W-1:0]   rel_ptr_s;
  logic [ID_W-1:0]   pick_ptr_s;
  logic              pick_found_s;
  logic [ID_W-1:0]   pick_idx_s;
  logic [N_REQ-1:0]  pick_oh_s;
  logic [MAX_REQ-1:0] grant_ext_s;

  // Release decode: the owner either drops its request or uses up its slice.
  // An owner that drops req on its last slice cycle counts as an early
  // release, so expire_s also requires the owner's req to be high.
  always_comb begin
    owner_req_s = req[grant_id_r];
    timeout_s   = (cnt_r == CNT_LAST);
    if (state_r == ST_GRANT) begin
      release_s = (~owner_req_s) | timeout_s;
      expire_s  = owner_req_s & timeout_s;
    end else begin
      release_s = 1'b0;
      expire_s  = 1'b0;
    end
  end

  // Pointer after a release: one past the owner, wrapping at N_REQ-1.
  always_comb begin
    if (grant_id_r == ID_LAST) begin
      rel_ptr_s = ID_ZERO;
    end else begin
      rel_ptr_s = grant_id_r + ID_ONE;
    end
  end

  // On a release the search must already use the advanced pointer so the
  // hand-over happens without an idle cycle.
  always_comb begin
    if (release_s) begin
      pick_ptr_s = rel_ptr_s;
    end else begin
      pick_ptr_s = ptr_r;
    end
  end

  rr_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .req   (req),
    .ptr   (pick_ptr_s),
    .found (pick_found_s),
    .index (pick_idx_s)
  );

  // One-hot form of the search result.
  always_comb begin
    pick_oh_s = ONE_HOT0 << pick_idx_s;
  end

  // FSM next state, grant selection and slice counter.
  always_comb begin
    state_nxt_s = state_r;
    ptr_nxt_s   = ptr_r;
    cnt_nxt_s   = cnt_r;
    grant_nxt_s = grant_r;
    case (state_r)
      ST_IDLE: begin
        cnt_nxt_s = CNT_ZERO;
        if (pick_found_s) begin
          state_nxt_s = ST_GRANT;
          grant_nxt_s = pick_oh_s;
        end else begin
          state_nxt_s = ST_IDLE;
          grant_nxt_s = {N_REQ{1'b0}};
        end
      end
      ST_GRANT: begin
        if (release_s) begin
          ptr_nxt_s = rel_ptr_s;
          cnt_nxt_s = CNT_ZERO;
          if (pick_found_s) begin
            // Also covers a lone owner being re-granted after timeout.
            state_nxt_s = ST_GRANT;
            grant_nxt_s = pick_oh_s;
          end else begin
            state_nxt_s = ST_IDLE;
            grant_nxt_s = {N_REQ{1'b0}};
          end
        end else begin
          state_nxt_s = ST_GRANT;
          grant_nxt_s = grant_r;
          // Saturate rather than wrap; in practice timeout fires first.
          if (cnt_r == CNT_MAX) begin
            cnt_nxt_s = cnt_r;
          end else begin
            cnt_nxt_s = cnt_r + CNT_ONE;
          end
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        ptr_nxt_s   = ID_ZERO;
        cnt_nxt_s   = CNT_ZERO;
        grant_nxt_s = {N_REQ{1'b0}};
      end
    endcase
  end

  // Derived output values, computed from the next grant so they register
  // together with it.
  always_comb begin
    grant_ext_s              = {MAX_REQ{1'b0}};
    grant_ext_s[N_REQ-1:0]   = grant_nxt_s;
    grant_valid_nxt_s        = |grant_nxt_s;
    grant_id_nxt_s           = ID_W'(onehot_to_id(grant_ext_s));
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      ptr_r         <= ID_ZERO;
      cnt_r         <= CNT_ZERO;
      grant_r       <= {N_REQ{1'b0}};
      grant_valid_r <= 1'b0;
      grant_id_r    <= ID_ZERO;
    end else begin
      state_r       <= state_nxt_s;
      ptr_r         <= ptr_nxt_s;
      cnt_r         <= cnt_nxt_s;
      grant_r       <= grant_nxt_s;
      grant_valid_r <= grant_valid_nxt_s;
      grant_id_r    <= grant_id_nxt_s;
    end
  end

  assign grant       = grant_r;
  assign grant_valid = grant_valid_r;
  assign grant_id    = grant_id_r;

  // The pulse belongs to the final slice cycle itself, so it is decoded from
  // registered state and the live owner req; it is held low during reset.
  assign slice_expired = expire_s & ~reset;

endmodule

// File: tb/tb_rr_slice_arbiter.sv
// tb_rr_slice_arbiter -- self-checking bench for rr_slice_arbiter
// (N_REQ=4, SLICE_CYCLES=4): a vector table, hand sequences for the
// multi-cycle cases, and a random phase against a behavioural model.
module tb_rr_slice_arbiter;

  localparam int N = 4;
  localparam int S = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic [3:0] grant;
  logic       grant_valid;
  logic [1:0] grant_id;
  logic       slice_expired;

  int vectors    = 0;
  int miscompares = 0;

  rr_slice_arbiter #(
    .N_REQ        (N),
    .SLICE_CYCLES (S),
    .CNT_W        (32)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req           (req),
    .grant         (grant),
    .grant_valid   (grant_valid),
    .grant_id      (grant_id),
    .slice_expired (slice_expired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] rq;
    logic [3:0] g;
    logic [1:0] id;
    logic       v;
    logic       ex;
  } vec_t;

  vec_t tbl [21];

  // behavioural model state: owner index (-1 = nobody), pointer, cycles held
  int m_owner;
  int m_ptr;
  int m_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic rst, input logic [3:0] r);
    reset = rst;
    req   = r;
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_in(1'b1, 4'b0000);
    tick();
  endtask

  function automatic int find_from(input logic [3:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic model_step(input logic rst, input logic [3:0] r);
    int nx;
    if (rst) begin
      m_owner = -1; m_ptr = 0; m_cnt = 0;
    end else if (m_owner < 0) begin
      nx = find_from(r, m_ptr);
      if (nx >= 0) begin m_owner = nx; m_cnt = 0; end
    end else if (!r[m_owner] || m_cnt == S - 1) begin
      m_ptr   = (m_owner + 1) % N;
      m_owner = find_from(r, m_ptr);
      m_cnt   = 0;
    end else begin
      m_cnt++;
    end
  endtask

  initial begin
    logic [3:0] exp_g;
    logic [3:0] cur;
    logic       rst;
    logic       exp_ex;
    int         own;

    reset = 1'b1;
    req   = 4'b0000;
    repeat (3) tick();

    // rst, req, grant, id, valid, expired
    tbl[0]  = '{1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0}; // reset state
    tbl[1]  = '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0}; // idle, no req
    tbl[2]  = '{1'b0, 4'b1000, 4'b0000, 2'd0, 1'b0, 1'b0}; // req 3 appears
    tbl[3]  = '{1'b0, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0}; // granted after 1
    tbl[4]  = '{1'b0, 4'b0000, 4'b1000, 2'd3, 1'b1, 1'b0}; // drop -> release
    tbl[5]  = '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0}; // idle
    tbl[6]  = '{1'b0, 4'b0101, 4'b0000, 2'd0, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 4'b0101, 4'b0001, 2'd0, 1'b1, 1'b0}; // owner 0, cycle 1
    tbl[8]  = '{1'b0, 4'b0100, 4'b0001, 2'd0, 1'b1, 1'b0}; // owner drops, cycle 2
    tbl[9]  = '{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0}; // moved to 2
    tbl[10] = '{1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0}; // reset in cycle 2
    tbl[11] = '{1'b0, 4'b1100, 4'b0000, 2'd0, 1'b0, 1'b0}; // all cleared
    tbl[12] = '{1'b0, 4'b1100, 4'b0100, 2'd2, 1'b1, 1'b0}; // restart from 0
    tbl[13] = '{1'b0, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0};
    tbl[14] = '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0}; // ptr now 3
    tbl[15] = '{1'b0, 4'b0001, 4'b0000, 2'd0, 1'b0, 1'b0}; // search wraps to 0
    tbl[16] = '{1'b0, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0};
    tbl[17] = '{1'b0, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0};
    tbl[18] = '{1'b0, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0};
    tbl[19] = '{1'b0, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0}; // timeout + drop: no pulse
    tbl[20] = '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};

    for (int i = 0; i < 21; i++) begin
      set_in(tbl[i].rst, tbl[i].rq);
      check($sformatf("tbl%0d_grant", i), 32'(grant), 32'(tbl[i].g));
      check($sformatf("tbl%0d_id", i), 32'(grant_id), 32'(tbl[i].id));
      check($sformatf("tbl%0d_valid", i), 32'(grant_valid), 32'(tbl[i].v));
      check($sformatf("tbl%0d_expired", i), 32'(slice_expired), 32'(tbl[i].ex));
      tick();
    end

    // all four requesting: each owns 4 cycles in turn, pulse on the 4th
    do_reset();
    for (int c = 0; c <= 16; c++) begin
      set_in(1'b0, 4'b1111);
      exp_g  = (c == 0) ? 4'b0000 : 4'(1 << ((c - 1) / 4));
      exp_ex = (c != 0) && ((c - 1) % 4 == 3);
      check($sformatf("all4_c%0d_grant", c), 32'(grant), 32'(exp_g));
      check($sformatf("all4_c%0d_expired", c), 32'(slice_expired), 32'(exp_ex));
      tick();
    end

    // requesters 0 and 2 alternate every 4 cycles with no gaps
    do_reset();
    for (int c = 0; c <= 16; c++) begin
      set_in(1'b0, 4'b0101);
      exp_g  = (c == 0) ? 4'b0000 : ((((c - 1) / 4) % 2 == 0) ? 4'b0001 : 4'b0100);
      exp_ex = (c != 0) && ((c - 1) % 4 == 3);
      check($sformatf("alt_c%0d_grant", c), 32'(grant), 32'(exp_g));
      check($sformatf("alt_c%0d_expired", c), 32'(slice_expired), 32'(exp_ex));
      tick();
    end

    // lone requester 1: continuous grant, pulse every 4th cycle
    do_reset();
    for (int c = 0; c <= 12; c++) begin
      set_in(1'b0, 4'b0010);
      exp_g  = (c == 0) ? 4'b0000 : 4'b0010;
      exp_ex = (c == 4) || (c == 8) || (c == 12);
      check($sformatf("solo_c%0d_grant", c), 32'(grant), 32'(exp_g));
      check($sformatf("solo_c%0d_id", c), 32'(grant_id), (c == 0) ? 32'd0 : 32'd1);
      check($sformatf("solo_c%0d_expired", c), 32'(slice_expired), 32'(exp_ex));
      tick();
    end

    // random phase against the behavioural model
    do_reset();
    m_owner = -1; m_ptr = 0; m_cnt = 0;
    cur = 4'b0000;
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 3) == 0) cur = 4'($urandom_range(0, 15));
      set_in(rst, cur);
      own    = m_owner;
      exp_g  = (own < 0) ? 4'b0000 : 4'(1 << own);
      exp_ex = !rst && (own >= 0) && cur[own] && (m_cnt == S - 1);
      check($sformatf("rnd%0d_grant", c), 32'(grant), 32'(exp_g));
      check($sformatf("rnd%0d_id", c), 32'(grant_id), (own < 0) ? 32'd0 : 32'(own));
      check($sformatf("rnd%0d_valid", c), 32'(grant_valid), 32'(own >= 0));
      check($sformatf("rnd%0d_expired", c), 32'(slice_expired), 32'(exp_ex));
      model_step(rst, cur);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
